memory_cycle: RTL and testbench

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/memory_cycle.sv | 83 ++++++++
 tb/tb_memory_cycle.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
// M/W pipeline stage: word-addressed data memory plus the M->W register bank and writeback mux.
// Optional misaligned-access detection is enabled with `define DMEM_ALIGN_CHECK_EN.
module memory_cycle #(
    parameter int unsigned DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ResultW,
    output logic        MisalignW
);

    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    logic [31:0]   mem [DMEM_DEPTH];
    logic [AW-1:0] wordIdx;
    logic [31:0]   readData;
    logic          storeEn;
    logic          misalign;

    // Upper address bits are dropped, so accesses wrap modulo the memory size.
    assign wordIdx  = ALU_ResultM[AW+1:2];
    assign readData = mem[wordIdx];

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned stores are dropped; misaligned loads only raise the flag.
    assign misalign = (MemWriteM || (ResultSrcM == 2'b01)) && (ALU_ResultM[1:0] != 2'b00);
    assign storeEn  = MemWriteM && (ALU_ResultM[1:0] == 2'b00);
`else
    assign misalign = 1'b0;
    assign storeEn  = MemWriteM;
`endif

    // Memory is never cleared; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst && storeEn) begin
            mem[wordIdx] <= WriteDataM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            ALU_ResultW <= 32'h0;
            ReadDataW   <= 32'h0;
            RD_W        <= 5'h0;
            PCPlus4W    <= 32'h0;
            MisalignW   <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM;
            ResultSrcW  <= ResultSrcM;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= readData;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            MisalignW   <= misalign;
        end
    end

    // Writeback select; also feeds the E-stage forwarding path.
    always_comb begin
        ResultW = ALU_ResultW;
        case (ResultSrcW)
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = ALU_ResultW;
        endcase
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: reset, store/load, wrap, writeback mux, reset persistence, alignment.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALU_ResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ResultW;
    logic        MisalignW;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    memory_cycle #(.DMEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALU_ResultW(ALU_ResultW),
        .ReadDataW(ReadDataW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
        .ResultW(ResultW), .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mw, input logic [1:0] src,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc4);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = src;
        ALU_ResultM = addr;
        WriteDataM  = wd;
        RD_M        = rd;
        PCPlus4M    = pc4;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_regwrite"}, 32'(RegWriteW), 32'h0);
        check({tag, "_src"},      32'(ResultSrcW), 32'h0);
        check({tag, "_alu"},      ALU_ResultW, 32'h0);
        check({tag, "_rdata"},    ReadDataW, 32'h0);
        check({tag, "_rd"},       32'(RD_W), 32'h0);
        check({tag, "_pc4"},      PCPlus4W, 32'h0);
        check({tag, "_result"},   ResultW, 32'h0);
        check({tag, "_misalign"}, 32'(MisalignW), 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 1'b1, 2'b10, 32'h40, 32'hBAD0BAD0, 5'd3, 32'h100);
        tick();
        checkAllZero("por");

        // Seed a word, then hold reset with random stores aimed at it.
        rst = 1'b1;
        drive(1'b0, 1'b1, 2'b00, 32'h40, 32'h11111111, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'b1, 2'($urandom), 32'h40, $urandom, 5'($urandom), $urandom);
            tick();
            checkAllZero("rst_hold");
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 5'd0, 32'h0);
        tick();
        check("rst_mem_kept", ReadDataW, 32'h11111111);

        // Store then load.
        drive(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 2'b01, 32'h10, 32'h0, 5'd5, 32'h0);
        tick();
        check("ld_rdata", ReadDataW, 32'hDEADBEEF);
        check("ld_result", ResultW, 32'hDEADBEEF);
        check("ld_rd", 32'(RD_W), 32'd5);
        check("ld_regwrite", 32'(RegWriteW), 32'd1);

        // Same-cycle read/write sees old data; new data next cycle.
        drive(1'b0, 1'b1, 2'b01, 32'h10, 32'h00002222, 5'd0, 32'h0);
        tick();
        check("rw_old", ReadDataW, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 2'b01, 32'h10, 32'h0, 5'd0, 32'h0);
        tick();
        check("rw_new", ReadDataW, 32'h00002222);

        // Address wrap modulo 4*DEPTH.
        drive(1'b0, 1'b1, 2'b00, 32'h1000, 32'h1234, 5'd0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 2'b01, 32'h0, 32'h0, 5'd0, 32'h0);
        tick();
        check("wrap_rdata", ReadDataW, 32'h1234);
        drive(1'b0, 1'b0, 2'b01, 32'h80000000, 32'h0, 5'd0, 32'h0);
        tick();
        check("wrap_high", ReadDataW, 32'h1234);

        // Writeback mux: word at 0x4 holds 9, ALU result 7 indexes it.
        drive(1'b0, 1'b1, 2'b00, 32'h4, 32'd9, 5'd0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 2'b00, 32'd7, 32'h0, 5'd1, 32'h24);
        tick();
        check("mux_00", ResultW, 32'd7);
        check("mux_alu", ALU_ResultW, 32'd7);
        check("mux_pc4", PCPlus4W, 32'h24);
        ResultSrcM = 2'b01;
        tick();
        check("mux_01", ResultW, 32'd9);
        ResultSrcM = 2'b10;
        tick();
        check("mux_10", ResultW, 32'h24);
        ResultSrcM = 2'b11;
        tick();
        check("mux_11", ResultW, 32'd7);

        // Reset pulse mid-operation leaves memory intact.
        drive(1'b0, 1'b1, 2'b00, 32'h20, 32'hA5A5A5A5, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);
        tick();
        check("pulse_zero", ResultW, 32'h0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b01, 32'h20, 32'h0, 5'd7, 32'h0);
        tick();
        check("pulse_mem", ReadDataW, 32'hA5A5A5A5);
        check("pulse_rd", 32'(RD_W), 32'd7);

        // Misaligned store over a word holding 1.
        drive(1'b0, 1'b1, 2'b00, 32'h20, 32'h1, 5'd0, 32'h0);
        tick();
        check("al_pre_flag", 32'(MisalignW), 32'h0);
        drive(1'b0, 1'b1, 2'b00, 32'h22, 32'hFFFFFFFF, 5'd0, 32'h0);
        tick();
        check("al_flag", 32'(MisalignW), ALIGN_EN ? 32'h1 : 32'h0);
        drive(1'b0, 1'b0, 2'b01, 32'h20, 32'h0, 5'd0, 32'h0);
        tick();
        check("al_word", ReadDataW, ALIGN_EN ? 32'h1 : 32'hFFFFFFFF);
        check("al_flag_clr", 32'(MisalignW), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
